// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter.
package mem_port_arbiter_pkg;

   localparam int REQUESTERS      = 3;
   localparam int DATA_WIDTH      = 16;
   localparam int ADDR_WIDTH      = 16;
   localparam int MAX_OUTSTANDING = 4;

   typedef logic [$clog2(REQUESTERS)-1:0] req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Round-robin picker with a grant lock that holds the winner while the slave stalls.
module mem_port_arbiter_rr_grant #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  valid_i,
   input  logic          ready_i,
   input  logic          block_i,
   output logic          gnt_valid_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          hs_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] pick;
   logic          found;

   always_comb begin
      int c;
      found = 1'b0;
      pick  = ptr_q;
      c     = 0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr_q) + i;
         if (c >= N) c = c - N;
         if (!found && valid_i[IW'(c)]) begin
            found = 1'b1;
            pick  = IW'(c);
         end
      end
      // A stalled grant stays with its owner regardless of new arrivals.
      if (lock_q) begin
         pick  = lock_idx_q;
         found = valid_i[lock_idx_q];
      end

      gnt_valid_o = found && !block_i;
      gnt_idx_o   = pick;
      hs_o        = gnt_valid_o && ready_i;

      ptr_d = ptr_q;
      if (hs_o) ptr_d = (int'(pick) + 1 >= N) ? '0 : pick + 1'b1;
      lock_d     = gnt_valid_o && !ready_i;
      lock_idx_d = pick;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one split read/write slave port between REQUESTERS masters; read
// responses are routed back through an in-order ID FIFO.
module mem_port_arbiter
   import mem_port_arbiter_pkg::REQUESTERS;
   import mem_port_arbiter_pkg::req_id_t;
#(
   parameter int DATA_WIDTH      = mem_port_arbiter_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH      = mem_port_arbiter_pkg::ADDR_WIDTH,
   parameter int MAX_OUTSTANDING = mem_port_arbiter_pkg::MAX_OUTSTANDING
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] s_r_addr,
   input  logic [REQUESTERS-1:0]                 s_r_avalid,
   output logic [REQUESTERS-1:0]                 s_r_aready,
   output logic [REQUESTERS-1:0]                 s_r_dvalid,
   output logic [DATA_WIDTH-1:0]                 s_r_data,
   input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] s_w_addr,
   input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] s_w_data,
   input  logic [REQUESTERS-1:0]                 s_w_valid,
   output logic [REQUESTERS-1:0]                 s_w_ready,
   output logic [ADDR_WIDTH-1:0]                 m_r_addr,
   output logic                                  m_r_avalid,
   input  logic                                  m_r_aready,
   input  logic                                  m_r_dvalid,
   input  logic [DATA_WIDTH-1:0]                 m_r_data,
   output logic [ADDR_WIDTH-1:0]                 m_w_addr,
   output logic [DATA_WIDTH-1:0]                 m_w_data,
   output logic                                  m_w_valid,
   input  logic                                  m_w_ready,
   output logic                                  err_unexpected
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam int IW = $bits(req_id_t);

   req_id_t       r_idx, w_idx;
   logic          r_hs, w_hs;
   logic          fifo_full, fifo_empty, push, pop;
   req_id_t       fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q;

   assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   assign push       = r_hs;
   assign pop        = m_r_dvalid && !fifo_empty;

   // Full is registered occupancy, so a pop while full frees a grant only next cycle.
   mem_port_arbiter_rr_grant #(.N(REQUESTERS), .IW(IW)) u_rd_grant (
      .clk         (clk),
      .rst_n       (reset_n),
      .valid_i     (s_r_avalid),
      .ready_i     (m_r_aready),
      .block_i     (fifo_full),
      .gnt_valid_o (m_r_avalid),
      .gnt_idx_o   (r_idx),
      .hs_o        (r_hs)
   );

   mem_port_arbiter_rr_grant #(.N(REQUESTERS), .IW(IW)) u_wr_grant (
      .clk         (clk),
      .rst_n       (reset_n),
      .valid_i     (s_w_valid),
      .ready_i     (m_w_ready),
      .block_i     (1'b0),
      .gnt_valid_o (m_w_valid),
      .gnt_idx_o   (w_idx),
      .hs_o        (w_hs)
   );

   always_comb begin
      m_r_addr          = s_r_addr[r_idx];
      s_r_aready        = '0;
      s_r_aready[r_idx] = r_hs;
      m_w_addr          = s_w_addr[w_idx];
      m_w_data          = s_w_data[w_idx];
      s_w_ready         = '0;
      s_w_ready[w_idx]  = w_hs;
      s_r_data          = m_r_data;
      s_r_dvalid        = '0;
      s_r_dvalid[fifo_q[rptr_q]] = pop;
      err_unexpected    = err_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wptr_q] <= r_idx;
            wptr_q         <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
         if (m_r_dvalid && fifo_empty) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, random traffic vs. model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int N = REQUESTERS;

   logic clk, reset_n;
   logic [N-1:0][ADDR_WIDTH-1:0] s_r_addr, s_w_addr;
   logic [N-1:0][DATA_WIDTH-1:0] s_w_data;
   logic [N-1:0] s_r_avalid, s_r_aready, s_r_dvalid, s_w_valid, s_w_ready;
   logic [DATA_WIDTH-1:0] s_r_data, m_r_data, m_w_data;
   logic [ADDR_WIDTH-1:0] m_r_addr, m_w_addr;
   logic m_r_avalid, m_r_aready, m_r_dvalid, m_w_valid, m_w_ready, err_unexpected;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .s_r_addr(s_r_addr), .s_r_avalid(s_r_avalid), .s_r_aready(s_r_aready),
      .s_r_dvalid(s_r_dvalid), .s_r_data(s_r_data),
      .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
      .m_r_addr(m_r_addr), .m_r_avalid(m_r_avalid), .m_r_aready(m_r_aready),
      .m_r_dvalid(m_r_dvalid), .m_r_data(m_r_data),
      .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .err_unexpected(err_unexpected)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state: per-channel pointer and lock owner (-1 = none), ID queue, sticky error
   int m_rptr, m_wptr, m_rlock, m_wlock;
   int m_q[$];
   bit m_err;
   logic [N-1:0] last_rhs, last_whs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_zero();
      s_r_avalid = '0; s_w_valid = '0;
      m_r_aready = 1'b0; m_w_ready = 1'b0;
      m_r_dvalid = 1'b0; m_r_data = '0;
   endtask

   task automatic model_reset();
      m_rptr = 0; m_wptr = 0; m_rlock = -1; m_wlock = -1;
      m_q.delete();
      m_err = 1'b0;
   endtask

   // Drives happen at posedge+1, checks at posedge+5.
   task automatic mid();
      #4;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive_zero();
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Winner = valid requester closest at or after ptr going upward; a lock overrides.
   function automatic int pick(input logic [N-1:0] v, input int ptr, input int lock);
      int best;
      int bestd;
      best = -1;
      bestd = N;
      if (lock >= 0) return v[lock] ? lock : -1;
      for (int i = 0; i < N; i++) begin
         if (v[i] && ((i - ptr + N) % N) < bestd) begin
            best  = i;
            bestd = (i - ptr + N) % N;
         end
      end
      return best;
   endfunction

   task automatic model_cycle();
      int rg, wg;
      logic [N-1:0] e_sra, e_swr, e_sdv;
      rg = (m_q.size() == MAX_OUTSTANDING) ? -1 : pick(s_r_avalid, m_rptr, m_rlock);
      wg = pick(s_w_valid, m_wptr, m_wlock);
      e_sra = '0; e_swr = '0; e_sdv = '0;
      if (rg >= 0 && m_r_aready) e_sra[rg] = 1'b1;
      if (wg >= 0 && m_w_ready) e_swr[wg] = 1'b1;
      if (m_r_dvalid && m_q.size() > 0) e_sdv[m_q[0]] = 1'b1;

      chk("rnd_r_avalid", 32'(m_r_avalid), 32'(rg >= 0));
      if (rg >= 0) chk("rnd_r_addr", 32'(m_r_addr), 32'(s_r_addr[rg]));
      chk("rnd_r_aready", 32'(s_r_aready), 32'(e_sra));
      chk("rnd_r_dvalid", 32'(s_r_dvalid), 32'(e_sdv));
      if (e_sdv != '0) chk("rnd_r_data", 32'(s_r_data), 32'(m_r_data));
      chk("rnd_w_valid", 32'(m_w_valid), 32'(wg >= 0));
      if (wg >= 0) begin
         chk("rnd_w_addr", 32'(m_w_addr), 32'(s_w_addr[wg]));
         chk("rnd_w_data", 32'(m_w_data), 32'(s_w_data[wg]));
      end
      chk("rnd_w_ready", 32'(s_w_ready), 32'(e_swr));
      chk("rnd_err", 32'(err_unexpected), 32'(m_err));

      if (m_r_dvalid) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         else m_err = 1'b1;
      end
      if (rg >= 0) begin
         if (m_r_aready) begin
            m_q.push_back(rg); m_rptr = (rg + 1) % N; m_rlock = -1;
         end else m_rlock = rg;
      end else m_rlock = -1;
      if (wg >= 0) begin
         if (m_w_ready) begin
            m_wptr = (wg + 1) % N; m_wlock = -1;
         end else m_wlock = wg;
      end else m_wlock = -1;
      last_rhs = e_sra;
      last_whs = e_swr;
   endtask

   typedef struct {
      logic [N-1:0]          rv;
      logic                  ra;
      logic [N-1:0]          wv;
      logic                  wr;
      logic                  e_rav;
      logic [ADDR_WIDTH-1:0] e_raddr;
      logic [N-1:0]          e_sra;
      logic                  e_wv;
      logic [ADDR_WIDTH-1:0] e_waddr;
      logic [N-1:0]          e_swr;
   } vec_t;

   vec_t tbl [8];

   initial begin
      reset_n = 1'b0;
      s_r_addr = '0; s_w_addr = '0; s_w_data = '0;
      drive_zero();
      model_reset();

      // ---- table: single-cycle vectors from reset (rr_ptr = 0) ----
      tbl[0] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000};
      tbl[1] = '{3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0100, 3'b001, 1'b0, 16'h0000, 3'b000};
      tbl[2] = '{3'b110, 1'b1, 3'b000, 1'b1, 1'b1, 16'h0200, 3'b010, 1'b0, 16'h0000, 3'b000};
      tbl[3] = '{3'b100, 1'b0, 3'b100, 1'b1, 1'b1, 16'h0300, 3'b000, 1'b1, 16'h3000, 3'b100};
      tbl[4] = '{3'b111, 1'b1, 3'b110, 1'b1, 1'b1, 16'h0100, 3'b001, 1'b1, 16'h2000, 3'b010};
      tbl[5] = '{3'b000, 1'b1, 3'b011, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 16'h1000, 3'b000};
      tbl[6] = '{3'b101, 1'b0, 3'b101, 1'b1, 1'b1, 16'h0100, 3'b000, 1'b1, 16'h1000, 3'b001};
      tbl[7] = '{3'b010, 1'b1, 3'b111, 1'b0, 1'b1, 16'h0200, 3'b010, 1'b1, 16'h1000, 3'b000};
      s_r_addr = {16'h0300, 16'h0200, 16'h0100};
      s_w_addr = {16'h3000, 16'h2000, 16'h1000};
      s_w_data = {16'hC3C3, 16'hB2B2, 16'hA1A1};
      for (int k = 0; k < 8; k++) begin
         do_reset();
         s_r_avalid = tbl[k].rv; m_r_aready = tbl[k].ra;
         s_w_valid  = tbl[k].wv; m_w_ready  = tbl[k].wr;
         mid();
         chk("tbl_r_avalid", 32'(m_r_avalid), 32'(tbl[k].e_rav));
         if (tbl[k].e_rav) chk("tbl_r_addr", 32'(m_r_addr), 32'(tbl[k].e_raddr));
         chk("tbl_r_aready", 32'(s_r_aready), 32'(tbl[k].e_sra));
         chk("tbl_w_valid", 32'(m_w_valid), 32'(tbl[k].e_wv));
         if (tbl[k].e_wv) chk("tbl_w_addr", 32'(m_w_addr), 32'(tbl[k].e_waddr));
         chk("tbl_w_ready", 32'(s_w_ready), 32'(tbl[k].e_swr));
         chk("tbl_r_dvalid", 32'(s_r_dvalid), 32'h0);
         chk("tbl_err", 32'(err_unexpected), 32'h0);
      end

      // ---- reads from r0 and r1, responses routed in order ----
      do_reset();
      s_r_addr = {16'h0030, 16'h0020, 16'h0010};
      s_r_avalid = 3'b011; m_r_aready = 1'b1;
      mid();
      chk("rd2_addr0", 32'(m_r_addr), 32'h0010);
      chk("rd2_ready0", 32'(s_r_aready), 32'b001);
      nxt();
      s_r_avalid = 3'b010;
      mid();
      chk("rd2_addr1", 32'(m_r_addr), 32'h0020);
      chk("rd2_ready1", 32'(s_r_aready), 32'b010);
      nxt();
      s_r_avalid = 3'b000; m_r_dvalid = 1'b1; m_r_data = 16'hAAAA;
      mid();
      chk("rd2_dvalid0", 32'(s_r_dvalid), 32'b001);
      chk("rd2_data0", 32'(s_r_data), 32'hAAAA);
      nxt();
      m_r_data = 16'hBBBB;
      mid();
      chk("rd2_dvalid1", 32'(s_r_dvalid), 32'b010);
      chk("rd2_data1", 32'(s_r_data), 32'hBBBB);
      nxt();
      m_r_dvalid = 1'b0;
      mid();
      chk("rd2_err", 32'(err_unexpected), 32'h0);

      // ---- write rotation with all three valid ----
      do_reset();
      s_w_addr = {16'h3000, 16'h2000, 16'h1000};
      s_w_valid = 3'b111; m_w_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         mid();
         chk("wrot_ready", 32'(s_w_ready), 32'(1 << (k % N)));
         chk("wrot_addr", 32'(m_w_addr), 32'(16'h1000 * ((k % N) + 1)));
         nxt();
      end

      // ---- lock: r2 stalled, r0 arrives at cycle 2 ----
      do_reset();
      s_w_data = {16'hC3C3, 16'hB2B2, 16'hA1A1};
      s_w_valid = 3'b100; m_w_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) s_w_valid = 3'b101;
         mid();
         chk("lock_addr", 32'(m_w_addr), 32'h3000);
         chk("lock_data", 32'(m_w_data), 32'hC3C3);
         chk("lock_ready", 32'(s_w_ready), 32'h0);
         nxt();
      end
      m_w_ready = 1'b1;
      mid();
      chk("lock_release", 32'(s_w_ready), 32'b100);
      chk("lock_rel_addr", 32'(m_w_addr), 32'h3000);
      nxt();
      s_w_valid = 3'b001;
      mid();
      chk("lock_next", 32'(s_w_ready), 32'b001);
      chk("lock_next_addr", 32'(m_w_addr), 32'h1000);
      nxt();

      // ---- FIFO full: four reads, fifth waits for a pop ----
      do_reset();
      s_w_valid = '0;
      s_r_avalid = 3'b001; m_r_aready = 1'b1;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
         s_r_addr[0] = 16'h0400 + 16'(k);
         mid();
         chk("full_fill", 32'(s_r_aready), 32'b001);
         nxt();
      end
      for (int k = 0; k < 2; k++) begin
         mid();
         chk("full_avalid", 32'(m_r_avalid), 32'h0);
         chk("full_aready", 32'(s_r_aready), 32'h0);
         nxt();
      end
      m_r_dvalid = 1'b1; m_r_data = 16'h1234;
      mid();
      chk("full_pop", 32'(s_r_dvalid), 32'b001);
      chk("full_pop_avalid", 32'(m_r_avalid), 32'h0);
      nxt();
      m_r_dvalid = 1'b0;
      mid();
      chk("full_5th_avalid", 32'(m_r_avalid), 32'h1);
      chk("full_5th_aready", 32'(s_r_aready), 32'b001);
      nxt();
      s_r_avalid = '0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
         m_r_dvalid = 1'b1;
         mid();
         chk("full_drain", 32'(s_r_dvalid), 32'b001);
         nxt();
      end
      m_r_dvalid = 1'b0;
      mid();
      chk("full_err", 32'(err_unexpected), 32'h0);
      nxt();

      // ---- unexpected response with empty FIFO ----
      m_r_dvalid = 1'b1;
      mid();
      chk("unexp_dvalid", 32'(s_r_dvalid), 32'h0);
      chk("unexp_err_before", 32'(err_unexpected), 32'h0);
      nxt();
      m_r_dvalid = 1'b0;
      mid();
      chk("unexp_err", 32'(err_unexpected), 32'h1);
      nxt(); nxt(); nxt();
      mid();
      chk("unexp_sticky", 32'(err_unexpected), 32'h1);
      nxt();

      // ---- reset with two reads outstanding ----
      do_reset();
      mid();
      chk("rst_err_clear", 32'(err_unexpected), 32'h0);
      nxt();
      s_r_addr = {16'h0300, 16'h0200, 16'h0100};
      s_r_avalid = 3'b110; m_r_aready = 1'b1;
      mid();
      chk("rst_rd1", 32'(s_r_aready), 32'b010);
      nxt();
      s_r_avalid = 3'b100;
      mid();
      chk("rst_rd2", 32'(s_r_aready), 32'b100);
      nxt();
      s_r_avalid = '0;
      reset_n = 1'b0;
      mid();
      nxt();
      reset_n = 1'b1;
      s_r_avalid = 3'b111; m_r_aready = 1'b0;
      mid();
      chk("rst_ptr0", 32'(m_r_addr), 32'h0100);
      chk("rst_noready", 32'(s_r_aready), 32'h0);
      chk("rst_err_low", 32'(err_unexpected), 32'h0);
      nxt();
      s_r_avalid = '0;
      nxt();
      m_r_dvalid = 1'b1;
      mid();
      chk("rst_stale_dvalid", 32'(s_r_dvalid), 32'h0);
      nxt();
      m_r_dvalid = 1'b0;
      mid();
      chk("rst_stale_err", 32'(err_unexpected), 32'h1);
      nxt();

      // ---- randomized traffic against the reference model ----
      do_reset();
      last_rhs = '0; last_whs = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!s_r_avalid[i] || last_rhs[i]) begin
               s_r_avalid[i] = 1'($urandom_range(0, 1));
               s_r_addr[i]   = 16'($urandom);
            end
            if (!s_w_valid[i] || last_whs[i]) begin
               s_w_valid[i] = 1'($urandom_range(0, 1));
               s_w_addr[i]  = 16'($urandom);
               s_w_data[i]  = 16'($urandom);
            end
         end
         m_r_aready = ($urandom_range(0, 3) != 0);
         m_w_ready  = ($urandom_range(0, 3) != 0);
         m_r_dvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
         m_r_data   = 16'($urandom);
         mid();
         model_cycle();
         nxt();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
